msg_transmit_simulation: RTL and testbench
==========================================

Name: msg_transmit_simulation

Overview:
Simulation-only message source that builds one complete test frame on 128-bit beats each time it is triggered. Frame fields come from static configuration inputs. Output is a valid-qualified 128-bit stream that feeds the message transmit path in place of real traffic; a one-cycle done pulse marks frame completion.

Parameters:
PAYLOAD_SEED, 8'h00, value of payload byte 0; payload byte k = (PAYLOAD_SEED + k) mod 256.

Ports:
sys_clk_i  input  1  system clock; all logic on rising edge
rst_i  input  1  synchronous, active-high reset
msg_sim_en_i  input  1  trigger; each 0->1 transition starts one frame
msg_state_done_pluse_o  output  1  one-cycle pulse after last beat of a frame
sim_frame_header  input  32  frame sync word, e.g. 32'hFDF7EB90
sim_frame_len  input  16  frame length field; 0 = auto-compute
sim_frame_type  input  4  frame type
sim_frame_cnt  input  16  frame counter field value
sim_src_id  input  8  source ID
sim_des_id  input  8  destination ID
sim_data_type  input  8  data type
sim_data_channel  input  8  data channel
sim_data_field_len  input  16  payload length L in bytes
msg_sim_vld_o  output  1  beat valid
msg_sim_data_o  output  128  beat data

Behaviour:
- Interface: one clock (sys_clk_i); reset is synchronous and active-high (rst_i).
- Reset: msg_sim_vld_o=0, msg_sim_data_o=0, msg_state_done_pluse_o=0, FSM=IDLE, edge-detect register=0. Reset mid-frame aborts the frame immediately, with no done pulse.
- Trigger: register en_d <= msg_sim_en_i. Start condition is msg_sim_en_i & ~en_d while in IDLE. A held-high enable produces exactly one frame. Rising edges outside IDLE are ignored.
- At start, latch all sim_* inputs. Input changes during a frame have no effect.
- FSM states and transitions:
  - IDLE -> HEAD on start.
  - HEAD -> PAY when L > 0; HEAD -> TAIL when L = 0.
  - PAY -> TAIL after the last payload beat.
  - TAIL -> IDLE.
- Output beats are registered: the header beat is presented (vld=1) in the cycle after the clock edge that samples the start. Beats are contiguous with no gaps and no backpressure.
- Header beat bit map:
  - [127:96] header
  - [95:80] frame_len field
  - [79:76] frame_type
  - [75:64] 0
  - [63:48] frame_cnt
  - [47:40] src_id
  - [39:32] des_id
  - [31:24] data_type
  - [23:16] data_channel
  - [15:0] L
- frame_len field: if sim_frame_len != 0, pass it through unchanged. Otherwise compute 16 + 16*ceil(L/16) + 16, truncated to 16 bits.
- Payload beats: ceil(L/16) beats, 16 bytes per beat.
  - Payload byte 0 of each beat sits at [127:120], descending.
  - Byte index k is continuous across beats.
  - In the final payload beat, bytes beyond L are 0.
- Tail beat: [127:112] = 16-bit wrap-around sum of all L payload bytes; [111:0] = 0.
- Done: msg_state_done_pluse_o=1 for exactly the one cycle immediately after the tail beat's valid cycle. vld=0 in that cycle. The FSM is back in IDLE, so a new rising edge sampled in that cycle is accepted.
- vld=0 whenever the FSM is IDLE; data holds 0 when vld=0.
- L = 65535: 4096 payload beats, last beat carries 15 valid bytes. Auto frame_len wraps to 16'h0020.

Test Plan:
- Tie inputs: header FDF7EB90, len 0, type 2, cnt 1234, src 14, des 25, dtype 25, chan 14, L=12. Release reset, then raise en and hold.
  - Header beat = 128'hFDF7EB90_0030_2000_1234_1425_2514_000C.
  - Payload beat = 128'h00010203_04050607_08090A0B_00000000.
  - Tail = 128'h0042_0000...; done pulse next cycle.
  - Exactly one frame despite en held high.
- sim_frame_len=16'h0100, L=0 -> two beats (header with 0100 and L=0000; tail with checksum 0000), then done.
- L=17 with seed 0 -> payload beats 00..0F and 10 followed by 15 zero bytes; checksum 0x0088; auto len 0x0040.
- Toggle en low/high mid-frame -> ignored, single frame. Re-toggle after done -> second identical frame.
- Assert rst_i during a payload beat -> vld/data/done 0 next cycle, no done pulse; a following en rise restarts from the header.
- Change sim_* inputs mid-frame -> current frame unchanged; the next frame uses the new values.

Source files
------------

// File: rtl/msg_transmit_simulation.sv
// msg_transmit_simulation
// Simulation-only message source. Each rising edge of msg_sim_en_i seen while
// idle emits one frame on a 128-bit valid-qualified stream:
//   header beat, ceil(L/16) payload beats, tail beat (16-bit payload checksum).
// One cycle after the tail beat, msg_state_done_pluse_o pulses.
//
// Ports:
//   sys_clk_i              system clock, rising edge
//   rst_i                  synchronous active-high reset
//   msg_sim_en_i           trigger, rising edge starts a frame
//   sim_*                  static frame configuration, sampled at start
//   msg_sim_vld_o          beat valid
//   msg_sim_data_o         beat data (0 whenever valid is low)
//   msg_state_done_pluse_o one-cycle frame-complete pulse
//   msg_sim_state_o        current FSM state (debug)
//
// Handshake: msg_sim_vld_o qualifies msg_sim_data_o; there is no ready, the
// consumer must accept every beat in the cycle it is valid.
module msg_transmit_simulation #(
    parameter logic [7:0] PAYLOAD_SEED = 8'h00
) (
    input  logic         sys_clk_i,
    input  logic         rst_i,
    input  logic         msg_sim_en_i,
    output logic         msg_state_done_pluse_o,
    input  logic [31:0]  sim_frame_header,
    input  logic [15:0]  sim_frame_len,
    input  logic [3:0]   sim_frame_type,
    input  logic [15:0]  sim_frame_cnt,
    input  logic [7:0]   sim_src_id,
    input  logic [7:0]   sim_des_id,
    input  logic [7:0]   sim_data_type,
    input  logic [7:0]   sim_data_channel,
    input  logic [15:0]  sim_data_field_len,
    output logic         msg_sim_vld_o,
    output logic [127:0] msg_sim_data_o,
    output logic [1:0]   msg_sim_state_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HEAD = 2'd1;
    localparam logic [1:0] ST_PAY  = 2'd2;
    localparam logic [1:0] ST_TAIL = 2'd3;

    logic [1:0]   state_q, state_d;
    logic         en_q;
    logic         vld_q, vld_d;
    logic [127:0] data_q, data_d;
    logic         done_q, done_d;
    logic [15:0]  len_q, len_d;      // payload length L captured at start
    logic [16:0]  off_q, off_d;      // payload bytes already emitted
    logic [15:0]  csum_q, csum_d;    // running payload checksum

    logic         start;
    logic [16:0]  l_round;
    logic [15:0]  frame_len_c;
    logic [127:0] hdr_beat;
    logic [127:0] pay_beat;
    logic [15:0]  pay_sum;
    logic [16:0]  k_c;
    logic [7:0]   b_c;

    assign start = msg_sim_en_i & ~en_q & (state_q == ST_IDLE);

    // Auto length = header + rounded payload + tail, each 16 bytes; wraps at 16 bits.
    assign l_round     = {1'b0, sim_data_field_len} + 17'd15;
    assign frame_len_c = (sim_frame_len != 16'h0000) ? sim_frame_len
                                                     : ({l_round[15:4], 4'b0000} + 16'd32);

    // The header beat is built straight from the inputs on the start edge, so
    // only L needs to be held for the remainder of the frame.
    assign hdr_beat = {sim_frame_header, frame_len_c, sim_frame_type, 12'h000,
                       sim_frame_cnt, sim_src_id, sim_des_id, sim_data_type,
                       sim_data_channel, sim_data_field_len};

    // Next payload beat: byte j carries index off_q+j, zero past the end of L.
    always_comb begin
        pay_beat = '0;
        pay_sum  = '0;
        k_c      = '0;
        b_c      = '0;
        for (int j = 0; j < 16; j++) begin
            k_c = off_q + 17'(j);
            if (k_c < {1'b0, len_q}) begin
                b_c = PAYLOAD_SEED + k_c[7:0];
                pay_beat[127-8*j -: 8] = b_c;
                pay_sum = pay_sum + {8'h00, b_c};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        data_d  = data_q;
        done_d  = 1'b0;
        len_d   = len_q;
        off_d   = off_q;
        csum_d  = csum_q;
        case (state_q)
            ST_IDLE: begin
                vld_d  = 1'b0;
                data_d = '0;
                if (start) begin
                    len_d   = sim_data_field_len;
                    off_d   = '0;
                    csum_d  = '0;
                    vld_d   = 1'b1;
                    data_d  = hdr_beat;
                    state_d = ST_HEAD;
                end
            end
            ST_HEAD, ST_PAY: begin
                // Payload remains while fewer than L bytes have been sent;
                // with L = 0 this sends the header straight to the tail.
                if (off_q < {1'b0, len_q}) begin
                    data_d  = pay_beat;
                    csum_d  = csum_q + pay_sum;
                    off_d   = off_q + 17'd16;
                    state_d = ST_PAY;
                end else begin
                    data_d  = {csum_q, 112'h0};
                    state_d = ST_TAIL;
                end
            end
            ST_TAIL: begin
                vld_d   = 1'b0;
                data_d  = '0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                vld_d   = 1'b0;
                data_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            len_q   <= '0;
            off_q   <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= msg_sim_en_i;
            vld_q   <= vld_d;
            data_q  <= data_d;
            done_q  <= done_d;
            len_q   <= len_d;
            off_q   <= off_d;
            csum_q  <= csum_d;
        end
    end

    assign msg_sim_vld_o          = vld_q;
    assign msg_sim_data_o         = data_q;
    assign msg_state_done_pluse_o = done_q;
    assign msg_sim_state_o        = state_q;

endmodule

// File: tb/tb_msg_transmit_simulation.sv
// Directed bench for msg_transmit_simulation with hand-computed beats.
module tb_msg_transmit_simulation;

    logic         sys_clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         msg_sim_en_i = 1'b0;
    logic         msg_state_done_pluse_o;
    logic [31:0]  sim_frame_header;
    logic [15:0]  sim_frame_len;
    logic [3:0]   sim_frame_type;
    logic [15:0]  sim_frame_cnt;
    logic [7:0]   sim_src_id;
    logic [7:0]   sim_des_id;
    logic [7:0]   sim_data_type;
    logic [7:0]   sim_data_channel;
    logic [15:0]  sim_data_field_len;
    logic         msg_sim_vld_o;
    logic [127:0] msg_sim_data_o;
    logic [1:0]   msg_sim_state_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [127:0] exp_q[$];

    localparam logic [127:0] H12 = 128'hFDF7EB90_0030_2000_1234_1425_2514_000C;
    localparam logic [127:0] P12 = 128'h00010203_04050607_08090A0B_00000000;
    localparam logic [127:0] T12 = 128'h0042_0000_0000_0000_0000_0000_0000_0000;
    localparam logic [127:0] H0  = 128'hFDF7EB90_0100_2000_1234_1425_2514_0000;
    localparam logic [127:0] T0  = 128'h0;
    localparam logic [127:0] H17 = 128'hFDF7EB90_0040_2000_1234_1425_2514_0011;
    localparam logic [127:0] PA  = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    localparam logic [127:0] PB  = 128'h10000000_00000000_00000000_00000000;
    localparam logic [127:0] T17 = 128'h0088_0000_0000_0000_0000_0000_0000_0000;
    localparam logic [127:0] H16 = 128'hFDF7EB90_0030_2000_1234_1425_2514_0010;
    localparam logic [127:0] T16 = 128'h0078_0000_0000_0000_0000_0000_0000_0000;
    localparam logic [127:0] HN  = 128'h12345678_0040_5000_ABCD_0102_0304_0011;

    msg_transmit_simulation #(.PAYLOAD_SEED(8'h00)) dut (
        .sys_clk_i              (sys_clk_i),
        .rst_i                  (rst_i),
        .msg_sim_en_i           (msg_sim_en_i),
        .msg_state_done_pluse_o (msg_state_done_pluse_o),
        .sim_frame_header       (sim_frame_header),
        .sim_frame_len          (sim_frame_len),
        .sim_frame_type         (sim_frame_type),
        .sim_frame_cnt          (sim_frame_cnt),
        .sim_src_id             (sim_src_id),
        .sim_des_id             (sim_des_id),
        .sim_data_type          (sim_data_type),
        .sim_data_channel       (sim_data_channel),
        .sim_data_field_len     (sim_data_field_len),
        .msg_sim_vld_o          (msg_sim_vld_o),
        .msg_sim_data_o         (msg_sim_data_o),
        .msg_sim_state_o        (msg_sim_state_o)
    );

    // Clock / reset
    always #5 sys_clk_i = ~sys_clk_i;

    // Checking
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drivers
    task automatic step();
        @(posedge sys_clk_i);
        #1;
    endtask

    task automatic cfg_a(input logic [15:0] flen, input logic [15:0] l);
        sim_frame_header   = 32'hFDF7EB90;
        sim_frame_len      = flen;
        sim_frame_type     = 4'h2;
        sim_frame_cnt      = 16'h1234;
        sim_src_id         = 8'h14;
        sim_des_id         = 8'h25;
        sim_data_type      = 8'h25;
        sim_data_channel   = 8'h14;
        sim_data_field_len = l;
    endtask

    // Present one valid beat and compare against the scoreboard head.
    task automatic expect_beat(input string tag);
        logic [127:0] e;
        step();
        check({tag, "_vld"}, {127'h0, msg_sim_vld_o}, 128'h1);
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 128'h0, 128'h1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_data"}, msg_sim_data_o, e);
        end
    endtask

    task automatic expect_done(input string tag);
        step();
        check({tag, "_done_vld"},  {127'h0, msg_sim_vld_o}, 128'h0);
        check({tag, "_done_data"}, msg_sim_data_o, 128'h0);
        check({tag, "_done"},      {127'h0, msg_state_done_pluse_o}, 128'h1);
    endtask

    task automatic expect_idle(input string tag);
        step();
        check({tag, "_idle_vld"},  {127'h0, msg_sim_vld_o}, 128'h0);
        check({tag, "_idle_done"}, {127'h0, msg_state_done_pluse_o}, 128'h0);
    endtask

    task automatic run_frame(input string tag, input int n);
        for (int i = 0; i < n; i++) expect_beat(tag);
        expect_done(tag);
        expect_idle(tag);
    endtask

    initial begin
        cfg_a(16'h0000, 16'd12);
        rst_i = 1'b1;
        repeat (3) step();
        check("rst_vld",   {127'h0, msg_sim_vld_o}, 128'h0);
        check("rst_data",  msg_sim_data_o, 128'h0);
        check("rst_done",  {127'h0, msg_state_done_pluse_o}, 128'h0);
        check("rst_state", {126'h0, msg_sim_state_o}, 128'h0);
        rst_i = 1'b0;
        step();

        // L=12, enable held high: exactly one frame
        msg_sim_en_i = 1'b1;
        exp_q.push_back(H12);
        expect_beat("l12_hdr");
        check("l12_state_head", {126'h0, msg_sim_state_o}, 128'h1);
        exp_q.push_back(P12); exp_q.push_back(T12);
        run_frame("l12", 2);
        repeat (4) expect_idle("l12_held");

        // explicit frame_len, L=0: header then tail
        msg_sim_en_i = 1'b0;
        cfg_a(16'h0100, 16'd0);
        step();
        msg_sim_en_i = 1'b1;
        exp_q.push_back(H0); exp_q.push_back(T0);
        run_frame("l0", 2);

        // L=17: partial last beat
        msg_sim_en_i = 1'b0;
        cfg_a(16'h0000, 16'd17);
        step();
        msg_sim_en_i = 1'b1;
        exp_q.push_back(H17); exp_q.push_back(PA); exp_q.push_back(PB); exp_q.push_back(T17);
        run_frame("l17", 4);

        // L=16: exactly one full beat
        msg_sim_en_i = 1'b0;
        cfg_a(16'h0000, 16'd16);
        step();
        msg_sim_en_i = 1'b1;
        exp_q.push_back(H16); exp_q.push_back(PA); exp_q.push_back(T16);
        run_frame("l16", 3);

        // Enable toggled mid-frame is ignored, re-toggle after done repeats the frame
        msg_sim_en_i = 1'b0;
        cfg_a(16'h0000, 16'd17);
        step();
        msg_sim_en_i = 1'b1;
        exp_q.push_back(H17); exp_q.push_back(PA); exp_q.push_back(PB); exp_q.push_back(T17);
        expect_beat("tog");
        msg_sim_en_i = 1'b0;
        expect_beat("tog");
        msg_sim_en_i = 1'b1;
        expect_beat("tog");
        expect_beat("tog");
        expect_done("tog");
        expect_idle("tog");
        expect_idle("tog_after");
        msg_sim_en_i = 1'b0;
        step();
        msg_sim_en_i = 1'b1;
        exp_q.push_back(H17); exp_q.push_back(PA); exp_q.push_back(PB); exp_q.push_back(T17);
        run_frame("tog2", 4);

        // Rising edge sampled during the done cycle starts the next frame at once
        msg_sim_en_i = 1'b0;
        cfg_a(16'h0100, 16'd0);
        step();
        msg_sim_en_i = 1'b1;
        exp_q.push_back(H0); exp_q.push_back(T0);
        expect_beat("b2b");
        msg_sim_en_i = 1'b0;
        expect_beat("b2b");
        expect_done("b2b");
        msg_sim_en_i = 1'b1;
        exp_q.push_back(H0); exp_q.push_back(T0);
        expect_beat("b2b_next");
        check("b2b_next_done", {127'h0, msg_state_done_pluse_o}, 128'h0);
        run_frame("b2b_next", 1);

        // Reset during a payload beat aborts with no done pulse
        msg_sim_en_i = 1'b0;
        cfg_a(16'h0000, 16'd17);
        step();
        msg_sim_en_i = 1'b1;
        exp_q.push_back(H17); exp_q.push_back(PA);
        expect_beat("abort");
        expect_beat("abort");
        rst_i = 1'b1;
        msg_sim_en_i = 1'b0;
        step();
        check("abort_vld",  {127'h0, msg_sim_vld_o}, 128'h0);
        check("abort_data", msg_sim_data_o, 128'h0);
        check("abort_done", {127'h0, msg_state_done_pluse_o}, 128'h0);
        rst_i = 1'b0;
        expect_idle("abort_post");
        msg_sim_en_i = 1'b1;
        exp_q.push_back(H17); exp_q.push_back(PA); exp_q.push_back(PB); exp_q.push_back(T17);
        run_frame("restart", 4);

        // Inputs changed mid-frame only affect the next frame
        msg_sim_en_i = 1'b0;
        cfg_a(16'h0000, 16'd12);
        step();
        msg_sim_en_i = 1'b1;
        exp_q.push_back(H12);
        expect_beat("chg");
        sim_frame_header   = 32'h12345678;
        sim_frame_type     = 4'h5;
        sim_frame_cnt      = 16'hABCD;
        sim_src_id         = 8'h01;
        sim_des_id         = 8'h02;
        sim_data_type      = 8'h03;
        sim_data_channel   = 8'h04;
        sim_data_field_len = 16'd17;
        exp_q.push_back(P12); exp_q.push_back(T12);
        run_frame("chg", 2);
        msg_sim_en_i = 1'b0;
        step();
        msg_sim_en_i = 1'b1;
        exp_q.push_back(HN); exp_q.push_back(PA); exp_q.push_back(PB); exp_q.push_back(T17);
        run_frame("chg_next", 4);

        check("queue_empty", 128'(exp_q.size()), 128'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Absolute time bound so the bench always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
